bit64_divide_seq: RTL
=====================

# bit64_divide_seq

Sequential signed 64-bit integer divider for the ANC datapath; the inverse operation to the 64-bit multiply stage. It normalises adaptive-filter products and power estimates back into coefficient range. It accepts one dividend/divisor pair through a valid/ready handshake. It runs a radix-2 restoring division on magnitudes and returns a signed quotient and remainder through a second valid/ready handshake. Division truncates toward zero.

## Interface
- No parameters; width fixed at 64 bits to match the bit64_* arithmetic family.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept an operand pair
- dividend  input  64  signed two's-complement
- divisor  input  64  signed two's-complement
- out_valid  output  1  result present, held until taken
- out_ready  input  1  consumer takes result
- quotient  output  64  signed quotient
- remainder  output  64  signed remainder, sign follows dividend
- div_zero  output  1  result came from divisor == 0
- overflow  output  1  result came from -2^63 / -1

## Operation
- States:
  - IDLE: in_ready = 1.
  - CALC: 64 iterations; 6-bit counter runs from 63 down to 0.
  - FIX: apply signs.
  - DONE: out_valid = 1.
- Acceptance occurs when in_valid && in_ready at a rising edge. At that edge the block:
  - registers sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend);
  - loads |dividend| and |divisor| as 64-bit unsigned; |-2^63| = 2^63 is represented exactly.
- Each CALC iteration:
  - partial remainder R (65 bits) = {R[63:0], Q[63]};
  - Q = Q << 1;
  - if R >= |divisor|, then R -= |divisor| and Q[0] = 1.
- FIX:
  - quotient = sign_q ? -Q : Q;
  - remainder = sign_r ? -R : R;
  - go to DONE.
- Special cases are decided at acceptance and go directly to DONE, skipping CALC and FIX:
  - divisor == 0: div_zero = 1; result per Configuration.
  - dividend == 64'h8000_0000_0000_0000 and divisor == -1: overflow = 1; result per Configuration.
- DONE: quotient, remainder, div_zero and overflow hold stable while out_valid && !out_ready. On out_valid && out_ready the state goes to IDLE and the flags clear.
- Invariant: dividend = quotient * divisor + remainder and |remainder| < |divisor|, except in the two flagged cases.

## Timing
- Reset, asynchronous and immediate:
  - state goes to IDLE;
  - out_valid, quotient, remainder, div_zero and overflow are all 0;
  - counter is 0;
  - in_ready = 0 while rst is high and 1 on the first cycle after release.
- Normal latency: out_valid rises after the 65th rising edge following the acceptance edge (64 CALC edges plus 1 FIX edge).
- Special-case latency: out_valid rises immediately after the acceptance edge.
- in_ready is low from the acceptance edge until the edge that consumes the result. It goes high in the following cycle, so there is no same-edge accept-after-consume. Maximum throughput is one result per 67 cycles.
- in_valid during CALC, FIX or DONE is ignored; operands are sampled only at the acceptance edge.
- out_ready held high before out_valid: the result is consumed on the first DONE edge.
- rst asserted mid-CALC discards the operation; no result is emitted.

## Configuration
- BIT64_DIVIDE_SAT_EN defined (saturating mode):
  - divide-by-zero: quotient = 64'h7FFF_FFFF_FFFF_FFFF if dividend >= 0, else 64'h8000_0000_0000_0000; remainder = 0.
  - overflow: quotient = 64'h7FFF_FFFF_FFFF_FFFF; remainder = 0.
- BIT64_DIVIDE_SAT_EN undefined (raw mode):
  - divide-by-zero: quotient = 64'hFFFF_FFFF_FFFF_FFFF; remainder = dividend.
  - overflow: quotient = 64'h8000_0000_0000_0000; remainder = 0.
- div_zero and overflow flags behave identically in both modes.

## Test plan
- 100 / 7 -> quotient 14, remainder 2, flags 0; out_valid exactly 65 edges after acceptance.
- -100 / 7 -> -14, remainder -2; 100 / -7 -> -14, remainder 2; -100 / -7 -> 14, remainder -2.
- 5 / 0 -> div_zero = 1 after 1 edge:
  - with BIT64_DIVIDE_SAT_EN: quotient 64'h7FFF_FFFF_FFFF_FFFF, remainder 0;
  - without: quotient 64'hFFFF_FFFF_FFFF_FFFF, remainder 5.
- 64'h8000_0000_0000_0000 / -1 -> overflow = 1, remainder 0; quotient saturated or raw per macro. Separately, 64'h8000_0000_0000_0000 / 2 -> 64'hC000_0000_0000_0000, remainder 0.
- Back-pressure: hold out_ready = 0 for 10 cycles after out_valid -> outputs stable and in_ready = 0 throughout; toggling in_valid with new operands has no effect; accept on the first out_ready edge, then in_ready = 1 the next cycle.
- Assert rst 30 cycles into CALC -> all outputs 0 immediately; no out_valid afterwards; a following 9 / 3 returns 3, remainder 0.

Source files
------------

// File: rtl/bit64_divide_seq.sv
// Sequential signed 64-bit divider: radix-2 restoring division on magnitudes, then sign fix-up.
// Define BIT64_DIVIDE_SAT_EN for saturating divide-by-zero/overflow results; otherwise raw results are returned.
module bit64_divide_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;

  state_t      state, state_next;
  logic [5:0]  count;
  logic [63:0] rem_acc, quo_acc, den_mag;
  logic        sign_q, sign_r;

  logic        accept, is_zero, is_ovf, take;
  logic [63:0] dvd_mag, dsr_mag;
  logic [64:0] rem_shift, rem_sub;
  logic [63:0] zero_quo, zero_rem, ovf_quo, ovf_rem;

  assign accept  = in_valid && in_ready;
  assign is_zero = (divisor == 64'd0);
  assign is_ovf  = (dividend == MIN64) && (divisor == '1);
  assign dvd_mag = dividend[63] ? (~dividend + 64'd1) : dividend;
  assign dsr_mag = divisor[63]  ? (~divisor  + 64'd1) : divisor;

  // Partial remainder never exceeds the divisor magnitude, so the borrow bit decides the restore.
  assign rem_shift = {rem_acc, quo_acc[63]};
  assign rem_sub   = rem_shift - {1'b0, den_mag};
  assign take      = ~rem_sub[64];

  always_comb begin
`ifdef BIT64_DIVIDE_SAT_EN
    zero_quo = dividend[63] ? MIN64 : MAX64;
    zero_rem = 64'd0;
    ovf_quo  = MAX64;
    ovf_rem  = 64'd0;
`else
    zero_quo = '1;
    zero_rem = dividend;
    ovf_quo  = MIN64;
    ovf_rem  = 64'd0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE) && !rst;
    out_valid  = (state == DONE);
    case (state)
      IDLE: if (accept) state_next = (is_zero || is_ovf) ? DONE : CALC;
      CALC: if (count == 6'd0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 6'd0;
      rem_acc   <= 64'd0;
      quo_acc   <= 64'd0;
      den_mag   <= 64'd0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= 64'd0;
      remainder <= 64'd0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q   <= dividend[63] ^ divisor[63];
            sign_r   <= dividend[63];
            quo_acc  <= dvd_mag;
            den_mag  <= dsr_mag;
            rem_acc  <= 64'd0;
            count    <= 6'd63;
            div_zero <= is_zero;
            overflow <= is_ovf;
            if (is_zero) begin
              quotient  <= zero_quo;
              remainder <= zero_rem;
            end else if (is_ovf) begin
              quotient  <= ovf_quo;
              remainder <= ovf_rem;
            end
          end
        end
        CALC: begin
          rem_acc <= take ? rem_sub[63:0] : rem_shift[63:0];
          quo_acc <= {quo_acc[62:0], take};
          count   <= count - 6'd1;
        end
        FIX: begin
          quotient  <= sign_q ? (~quo_acc + 64'd1) : quo_acc;
          remainder <= sign_r ? (~rem_acc + 64'd1) : rem_acc;
        end
        DONE: begin
          if (out_ready) begin
            div_zero <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
